// File: rtl/data_memory_pkg.sv
// Shared types and helpers for the byte-enable data memory.
package data_memory_pkg;

    // Byte address width seen by the datapath.
    localparam int unsigned ADDR_W = 32;

    // Word width of the default datapath configuration.
    localparam int unsigned RESP_DATA_W = 32;

    // Controller state: the array is swept to zero before requests are served.
    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_e;

    // Response record at the default word width. The response pipeline
    // declares the same layout at its own DATA_W.
    typedef struct packed {
        logic                   valid;
        logic                   err;
        logic [RESP_DATA_W-1:0] data;
    } resp_t;

    // Flags a byte address that is either misaligned (offset bits set) or
    // outside the array (any bit above the word-index field set).
    function automatic logic addr_err(
        input logic [ADDR_W-1:0] addr,
        input int unsigned       off_w,
        input int unsigned       idx_w
    );
        logic [ADDR_W-1:0] lo_mask;
        logic [ADDR_W-1:0] hi_mask;
        lo_mask = (ADDR_W'(1) << off_w) - ADDR_W'(1);
        hi_mask = ~((ADDR_W'(1) << (off_w + idx_w)) - ADDR_W'(1));
        return (|(addr & lo_mask)) | (|(addr & hi_mask));
    endfunction

endpackage

// File: rtl/data_memory_be_resp_pipe.sv
// Fixed-latency, fully pipelined response delay line. Stage 0 captures the
// response on the accepting edge; the last stage drives the outputs, so
// every output comes straight from a flop.
module resp_pipe #(
    parameter int unsigned STAGES = 1,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    input  logic              in_err,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    output logic              out_err,
    output logic [DATA_W-1:0] out_data
);

    // Same layout as data_memory_pkg::resp_t, sized to this instance.
    typedef struct packed {
        logic              valid;
        logic              err;
        logic [DATA_W-1:0] data;
    } stage_t;

    stage_t stage_r [STAGES];

    // Shift responses one stage per cycle; reset empties every stage so
    // in-flight responses are dropped and the outputs read as zero.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int k = 0; k < STAGES; k++) begin
                stage_r[k] <= '0;
            end
        end else begin
            stage_r[0] <= '{valid: in_valid, err: in_err, data: in_data};
            for (int k = 1; k < STAGES; k++) begin
                stage_r[k] <= stage_r[k-1];
            end
        end
    end

    assign out_valid = stage_r[STAGES-1].valid;
    assign out_err   = stage_r[STAGES-1].err;
    assign out_data  = stage_r[STAGES-1].data;

endmodule

// File: rtl/data_memory_be.sv
// Single-port data memory with request/ready handshake, byte-enable writes,
// byte addressing with alignment/range checks, a configurable-latency
// response pipeline and a post-reset hardware clear sweep.
module data_memory_be
    import data_memory_pkg::*;
#(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned DEPTH     = 64,
    parameter int unsigned READ_LAT  = 1,
    parameter              INIT_FILE = "DataMemory.txt"
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                req,
    input  logic                we,
    input  logic [31:0]         addr,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] be,
    output logic                ready,
    output logic                resp_valid,
    output logic [DATA_W-1:0]   rdata,
    output logic                err
);

    localparam int unsigned BYTES = DATA_W / 8;
    localparam int unsigned OFF_W = $clog2(BYTES);
    localparam int unsigned IDX_W = $clog2(DEPTH);

    // The clear sweep zeroes the array after every reset, so any image named
    // here would be overwritten before the first request; the parameter is
    // kept only so existing instantiations keep elaborating.
    if (INIT_FILE != "") begin : g_init_file_unused
    end

    state_e             state_r;
    state_e             state_s;
    logic [IDX_W-1:0]   clr_idx_r;
    logic [IDX_W-1:0]   clr_idx_s;
    logic               ready_r;

    logic               accept_s;
    logic               bad_s;
    logic               wr_en_s;
    logic [IDX_W-1:0]   word_idx_s;

    logic               pipe_valid_s;
    logic               pipe_err_s;
    logic [DATA_W-1:0]  pipe_data_s;

    logic [DATA_W-1:0]  mem_r [DEPTH];

    // Request decode: index field, address check and write qualification.
    assign accept_s   = req && (state_r == RUN);
    assign word_idx_s = addr[OFF_W +: IDX_W];
    assign bad_s      = addr_err(addr, OFF_W, IDX_W);
    assign wr_en_s    = accept_s && we && !bad_s && !reset;

    // Next-state logic: sweep every word once, then serve requests.
    always_comb begin
        state_s   = state_r;
        clr_idx_s = clr_idx_r;
        case (state_r)
            CLEAR: begin
                clr_idx_s = clr_idx_r + IDX_W'(1);
                if (clr_idx_r == IDX_W'(DEPTH - 1)) begin
                    state_s = RUN;
                end else begin
                    state_s = CLEAR;
                end
            end
            RUN: begin
                state_s = RUN;
            end
            default: begin
                state_s   = CLEAR;
                clr_idx_s = '0;
            end
        endcase
    end

    // State, sweep index and ready flag; reset restarts the sweep at word 0.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r   <= CLEAR;
            clr_idx_r <= '0;
            ready_r   <= 1'b0;
        end else begin
            state_r   <= state_s;
            clr_idx_r <= clr_idx_s;
            ready_r   <= (state_s == RUN);
        end
    end

    assign ready = ready_r;

    // Single write port: the sweep owns it in CLEAR, byte-enabled writes in RUN.
    always_ff @(posedge clock) begin
        if ((state_r == CLEAR) && !reset) begin
            mem_r[clr_idx_r] <= '0;
        end else if (wr_en_s) begin
            for (int b = 0; b < BYTES; b++) begin
                if (be[b]) begin
                    mem_r[word_idx_s][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    // Response entering the pipeline: read data only for good reads, zero
    // for writes and rejected accesses, bubble when nothing is accepted.
    always_comb begin
        pipe_valid_s = 1'b0;
        pipe_err_s   = 1'b0;
        pipe_data_s  = '0;
        if (accept_s) begin
            pipe_valid_s = 1'b1;
            pipe_err_s   = bad_s;
            if (!we && !bad_s) begin
                pipe_data_s = mem_r[word_idx_s];
            end else begin
                pipe_data_s = '0;
            end
        end else begin
            pipe_valid_s = 1'b0;
        end
    end

    resp_pipe #(
        .STAGES (READ_LAT),
        .DATA_W (DATA_W)
    ) u_resp_pipe (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (pipe_valid_s),
        .in_err    (pipe_err_s),
        .in_data   (pipe_data_s),
        .out_valid (resp_valid),
        .out_err   (err),
        .out_data  (rdata)
    );

endmodule

// File: tb/tb_data_memory_be.sv
// Directed bench for data_memory_be: three instances (READ_LAT 1, 2, 3)
// share one stimulus stream; each check targets the instance it concerns.
module tb_data_memory_be;

    logic        clock;
    logic        reset;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;

    logic        ready1, rv1, err1;
    logic [31:0] rdata1;
    logic        ready2, rv2, err2;
    logic [31:0] rdata2;
    logic        ready3, rv3, err3;
    logic [31:0] rdata3;

    int vectors;
    int miscompares;

    data_memory_be #(.DATA_W(32), .DEPTH(64), .READ_LAT(1)) dut1 (
        .clock(clock), .reset(reset), .req(req), .we(we), .addr(addr),
        .wdata(wdata), .be(be), .ready(ready1), .resp_valid(rv1),
        .rdata(rdata1), .err(err1)
    );

    data_memory_be #(.DATA_W(32), .DEPTH(64), .READ_LAT(2)) dut2 (
        .clock(clock), .reset(reset), .req(req), .we(we), .addr(addr),
        .wdata(wdata), .be(be), .ready(ready2), .resp_valid(rv2),
        .rdata(rdata2), .err(err2)
    );

    data_memory_be #(.DATA_W(32), .DEPTH(64), .READ_LAT(3)) dut3 (
        .clock(clock), .reset(reset), .req(req), .we(we), .addr(addr),
        .wdata(wdata), .be(be), .ready(ready3), .resp_valid(rv3),
        .rdata(rdata3), .err(err3)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Present one request for exactly one edge.
    task automatic do_req(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
        req   = 1'b1;
        we    = w;
        addr  = a;
        wdata = d;
        be    = b;
        tick();
        req   = 1'b0;
        we    = 1'b0;
    endtask

    // Release reset and confirm ready stays low for 63 edges and rises after the 64th.
    task automatic sweep_and_check(input string tag);
        logic early;
        logic pulse;
        early = 1'b0;
        pulse = 1'b0;
        reset = 1'b0;
        for (int i = 1; i <= 63; i++) begin
            tick();
            if (ready1 || ready2 || ready3) early = 1'b1;
            if (rv1 || rv2 || rv3) pulse = 1'b1;
        end
        check({tag, "_ready_low"}, {31'd0, early}, 32'd0);
        check({tag, "_no_resp"},   {31'd0, pulse}, 32'd0);
        tick();
        check({tag, "_ready_up"}, {29'd0, ready1, ready2, ready3}, 32'h7);
    endtask

    logic        obs_v [7];
    logic [31:0] obs_d [7];

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset = 1'b1;
        req   = 1'b0;
        we    = 1'b0;
        addr  = 32'h0;
        wdata = 32'h0;
        be    = 4'h0;
        tick();
        tick();

        // Reset outputs.
        check("rst_ready", {31'd0, ready1}, 32'd0);
        check("rst_rv",    {31'd0, rv1},    32'd0);
        check("rst_rdata", rdata1,          32'd0);
        check("rst_err",   {31'd0, err1},   32'd0);

        sweep_and_check("sweep1");

        // Plant a value in word 5, then prove the next sweep clears it.
        do_req(1'b1, 32'h14, 32'hDEADBEEF, 4'hF);
        check("wr14_rv",  {31'd0, rv1}, 32'd1);
        check("wr14_err", {31'd0, err1}, 32'd0);
        check("wr14_rd",  rdata1, 32'd0);
        do_req(1'b0, 32'h14, 32'h0, 4'h0);
        check("rd14_pre", rdata1, 32'hDEADBEEF);
        tick();
        tick();
        reset = 1'b1;
        tick();
        check("rst2_ready", {31'd0, ready1}, 32'd0);
        sweep_and_check("sweep2");
        do_req(1'b0, 32'h14, 32'h0, 4'h0);
        check("rd14_clr_rv",  {31'd0, rv1}, 32'd1);
        check("rd14_clr",     rdata1, 32'd0);
        check("rd14_clr_err", {31'd0, err1}, 32'd0);

        // Byte enables, including an all-zero no-op write.
        do_req(1'b1, 32'h08, 32'h11223344, 4'hF);
        do_req(1'b1, 32'h08, 32'hAABBCCDD, 4'b0101);
        check("be_wr_err", {31'd0, err1}, 32'd0);
        do_req(1'b0, 32'h08, 32'h0, 4'h0);
        check("be_rd", rdata1, 32'h11BB33DD);
        do_req(1'b1, 32'h08, 32'hFFFFFFFF, 4'h0);
        check("be0_rv",  {31'd0, rv1}, 32'd1);
        check("be0_err", {31'd0, err1}, 32'd0);
        do_req(1'b0, 32'h08, 32'h0, 4'h0);
        check("be0_rd", rdata1, 32'h11BB33DD);

        // Read immediately after a write to the same word.
        do_req(1'b1, 32'h10, 32'h5, 4'hF);
        do_req(1'b0, 32'h10, 32'h0, 4'h0);
        check("raw_rd", rdata1, 32'h5);

        // Pipelining on the 3-cycle instance.
        do_req(1'b1, 32'h00, 32'd1, 4'hF);
        do_req(1'b1, 32'h04, 32'd2, 4'hF);
        do_req(1'b1, 32'h08, 32'd3, 4'hF);
        do_req(1'b1, 32'h0C, 32'd4, 4'hF);
        for (int i = 0; i < 4; i++) tick();
        for (int k = 0; k < 7; k++) begin
            if (k < 4) begin
                req  = 1'b1;
                we   = 1'b0;
                addr = 32'(k * 4);
            end else begin
                req  = 1'b0;
            end
            tick();
            obs_v[k] = rv3;
            obs_d[k] = rdata3;
            if (k < 4) check("pipe_lat1", rdata1, 32'(k + 1));
        end
        req = 1'b0;
        check("pipe_v_e0", {31'd0, obs_v[0]}, 32'd0);
        check("pipe_v_e1", {31'd0, obs_v[1]}, 32'd0);
        check("pipe_v",    {28'd0, obs_v[2], obs_v[3], obs_v[4], obs_v[5]}, 32'hF);
        check("pipe_v_e6", {31'd0, obs_v[6]}, 32'd0);
        check("pipe_d1", obs_d[2], 32'd1);
        check("pipe_d2", obs_d[3], 32'd2);
        check("pipe_d3", obs_d[4], 32'd3);
        check("pipe_d4", obs_d[5], 32'd4);

        // Misaligned and out-of-range accesses.
        do_req(1'b1, 32'h06, 32'hFFFFFFFF, 4'hF);
        check("mis_err", {31'd0, err1}, 32'd1);
        check("mis_rd",  rdata1, 32'd0);
        do_req(1'b0, 32'h100, 32'h0, 4'h0);
        check("oor_err", {31'd0, err1}, 32'd1);
        check("oor_rd",  rdata1, 32'd0);
        do_req(1'b1, 32'h100, 32'hFFFFFFFF, 4'hF);
        check("oorw_err", {31'd0, err1}, 32'd1);
        do_req(1'b0, 32'h04, 32'h0, 4'h0);
        check("keep04", rdata1, 32'd2);
        check("keep04_err", {31'd0, err1}, 32'd0);
        do_req(1'b0, 32'h00, 32'h0, 4'h0);
        check("keep00", rdata1, 32'd1);

        // Reset while a read is in flight on the 2-cycle instance.
        for (int i = 0; i < 4; i++) tick();
        do_req(1'b0, 32'h04, 32'h0, 4'h0);
        reset = 1'b1;
        tick();
        check("mid_rv",    {31'd0, rv2},    32'd0);
        check("mid_ready", {31'd0, ready2}, 32'd0);
        sweep_and_check("sweep3");
        do_req(1'b0, 32'h04, 32'h0, 4'h0);
        check("mid_clr", rdata1, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
